ntt_bfly_pipe: RTL

- Parametrised, fully pipelined NTT butterfly over Z_Q, one butterfly per cycle.
- Selectable per transaction: Cooley-Tukey (forward NTT) or Gentleman-Sande (inverse NTT), with optional divide-by-2 for INTT scaling.
- Valid/ready handshake on both sides with full backpressure; user tag passthrough.
- Sits between the coefficient-memory read port and write-back logic of the NTT/INTT engine.

---
 rtl/ntt_bfly_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ntt_bfly_pipe.sv
// ntt_bfly_pipe: 4-stage pipelined CT/GS NTT butterfly over Z_Q with valid/ready flow control
module ntt_bfly_pipe #(
  parameter int DW   = 12,
  parameter int Q    = 3329,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic            in_half,
  input  logic [DW-1:0]   in_x,
  input  logic [DW-1:0]   in_y,
  input  logic [DW-1:0]   in_w,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_x,
  output logic [DW-1:0]   out_y,
  output logic [TAGW-1:0] out_tag,
  output logic            out_err,
  output logic            busy
);
  localparam int K = 2 * DW;
  localparam logic [DW-1:0] QN = DW'(Q);
  localparam logic [DW:0]   QD = (DW + 1)'(Q);
  localparam logic [K-1:0]  QK = K'(Q);
  // Barrett constant floor(2^K / Q); products are < 2^K so the quotient estimate is off by at most one
  localparam logic [K-1:0]  BM = K'((64'd1 << K) / 64'(Q));

  function automatic logic [DW-1:0] mod1(input logic [DW:0] v);
    return (v >= QD) ? DW'(v - QD) : DW'(v);
  endfunction

  function automatic logic [DW-1:0] halve(input logic [DW-1:0] v);
    return v[0] ? DW'(({1'b0, v} + QD) >> 1) : (v >> 1);
  endfunction

  logic            advance;
  logic            v1, v2, v3;
  logic [DW-1:0]   a1, m1, w1, a2, a3, r3;
  logic [K-1:0]    p2;
  logic            mode1, mode2, mode3, half1, half2, half3, err1, err2, err3;
  logic [TAGW-1:0] tag1, tag2, tag3;
  logic            err_in;
  logic [DW-1:0]   gs_a, gs_m;
  logic [2*K-1:0]  bp;
  logic [K-1:0]    bq, br0, br1, br2;
  logic [DW-1:0]   ct_x, ct_y, rx, ry, fx, fy;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign busy     = v1 || v2 || v3 || out_valid;

  // Input checks and the GS add/sub ahead of the first register
  always_comb begin
    err_in = (in_x >= QN) || (in_y >= QN) || (in_w >= QN);
    gs_a   = mod1({1'b0, in_x} + {1'b0, in_y});
    gs_m   = mod1({1'b0, in_x} + QD - {1'b0, in_y});
  end

  // Barrett reduction of the registered product, with two guard subtractions
  always_comb begin
    bp  = {{K{1'b0}}, p2} * {{K{1'b0}}, BM};
    bq  = K'(bp >> K);
    br0 = p2 - bq * QK;
    br1 = (br0 >= QK) ? br0 - QK : br0;
    br2 = (br1 >= QK) ? br1 - QK : br1;
  end

  // Final CT add/sub or GS passthrough, then optional halving
  always_comb begin
    ct_x = mod1({1'b0, a3} + {1'b0, r3});
    ct_y = mod1({1'b0, a3} + QD - {1'b0, r3});
    rx   = mode3 ? a3 : ct_x;
    ry   = mode3 ? r3 : ct_y;
    fx   = half3 ? halve(rx) : rx;
    fy   = half3 ? halve(ry) : ry;
  end

  // Whole pipe advances together; bubbles are preserved while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {v1, v2, v3, out_valid} <= '0;
      {a1, m1, w1, a2, a3, r3} <= '0;
      p2 <= '0;
      {mode1, mode2, mode3, half1, half2, half3, err1, err2, err3} <= '0;
      {tag1, tag2, tag3} <= '0;
      out_x   <= '0;
      out_y   <= '0;
      out_tag <= '0;
      out_err <= 1'b0;
    end else if (advance) begin
      v1        <= in_valid;
      a1        <= in_mode ? gs_a : in_x;
      m1        <= in_mode ? gs_m : in_y;
      w1        <= in_w;
      mode1     <= in_mode;
      half1     <= in_half;
      tag1      <= in_tag;
      err1      <= err_in;
      v2        <= v1;
      a2        <= a1;
      p2        <= K'(m1) * K'(w1);
      mode2     <= mode1;
      half2     <= half1;
      tag2      <= tag1;
      err2      <= err1;
      v3        <= v2;
      a3        <= a2;
      r3        <= DW'(br2);
      mode3     <= mode2;
      half3     <= half2;
      tag3      <= tag2;
      err3      <= err2;
      out_valid <= v3;
      out_x     <= fx;
      out_y     <= fy;
      out_tag   <= tag3;
      out_err   <= err3;
    end
  end
endmodule
